// File: rtl/issue_unit_pkg.sv
// ============================================================================
// Module : issue_unit_pkg
// Brief  : Shared widths, instruction field positions and enums for issue_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package issue_unit_pkg;

    localparam int REG_SIZE   = 6;
    localparam int WORD_SIZE  = 32;
    localparam int INSTR_BITS = 32;

    // Instruction word field positions
    localparam int UNIT_HI   = 31;
    localparam int UNIT_LO   = 30;
    localparam int HASIMM_B  = 29;
    localparam int REG1_HI   = 28;
    localparam int REG1_LO   = 23;
    localparam int REG2_HI   = 22;
    localparam int REG2_LO   = 17;
    localparam int REG3_HI   = 16;
    localparam int REG3_LO   = 11;

    typedef enum logic [1:0] {
        UNIT_LW  = 2'b00,
        UNIT_SW  = 2'b01,
        UNIT_ADD = 2'b10,
        UNIT_MUL = 2'b11
    } unit_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

endpackage

`default_nettype wire

// File: rtl/issue_fifo.sv
// ============================================================================
// Module : issue_fifo
// Brief  : Instruction FIFO with flush; exposes head and the entry behind it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module issue_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [WIDTH-1:0]           head_next,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    w_rd_next;
    logic             w_push;
    logic             w_pop;

    // A full FIFO refuses the push even when a pop frees a slot on the same edge
    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;
    assign w_rd_next = r_rd_ptr + AW'(1);

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign head_next = r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/issue_unit.sv
// ============================================================================
// Module : issue_unit
// Brief  : Buffers fetched instructions, decodes the head and issues it to the RS.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import issue_unit_pkg::*;

module issue_unit #(
    parameter int DEPTH    = 8,
    parameter int IMM_BITS = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [31:0]           instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [1:0]            unit,
    output logic [REG_SIZE-1:0]   reg1,
    output logic [REG_SIZE-1:0]   reg2,
    output logic [REG_SIZE-1:0]   reg3,
    output logic                  hasimm,
    output logic [WORD_SIZE-1:0]  imm,
    output logic                  enable,
    input  logic                  rs_out,
    output logic [15:0]           issued_cnt,
    output logic [15:0]           stall_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e                r_state;
    state_e                w_state_next;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_src_next;
    logic                  w_accept;
    logic                  w_reject;

    logic [31:0]           w_head;
    logic [31:0]           w_head_next;
    logic [31:0]           w_word;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;

    logic [1:0]            r_unit;
    logic [REG_SIZE-1:0]   r_reg1;
    logic [REG_SIZE-1:0]   r_reg2;
    logic [REG_SIZE-1:0]   r_reg3;
    logic                  r_hasimm;
    logic [WORD_SIZE-1:0]  r_imm;
    logic                  r_enable;
    logic [15:0]           r_issued_cnt;
    logic [15:0]           r_stall_cnt;

    issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (instr_valid),
        .pop       (w_pop),
        .wdata     (instr),
        .head      (w_head),
        .head_next (w_head_next),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_src_next   = 1'b0;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_state_next = ST_ISSUE;
                        w_load       = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    w_state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (rs_out) begin
                        w_pop    = 1'b1;
                        w_accept = 1'b1;
                        // Head is retiring on this edge, so the next issue decodes the entry behind it
                        if (w_count > CW'(1)) begin
                            w_state_next = ST_ISSUE;
                            w_load       = 1'b1;
                            w_src_next   = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_reject     = 1'b1;
                        w_state_next = ST_ISSUE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign w_word = w_src_next ? w_head_next : w_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_enable     <= 1'b0;
            r_unit       <= '0;
            r_reg1       <= '0;
            r_reg2       <= '0;
            r_reg3       <= '0;
            r_hasimm     <= 1'b0;
            r_imm        <= '0;
            r_issued_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_enable <= (w_state_next == ST_ISSUE);
            if (w_load) begin
                r_unit   <= w_word[UNIT_HI:UNIT_LO];
                r_reg1   <= w_word[REG1_HI:REG1_LO];
                r_reg2   <= w_word[REG2_HI:REG2_LO];
                r_hasimm <= w_word[HASIMM_B];
                if (w_word[HASIMM_B]) begin
                    r_reg3 <= '0;
                    r_imm  <= {{(WORD_SIZE-IMM_BITS){w_word[IMM_BITS-1]}}, w_word[IMM_BITS-1:0]};
                end else begin
                    r_reg3 <= w_word[REG3_HI:REG3_LO];
                    r_imm  <= '0;
                end
            end
            if (w_accept) r_issued_cnt <= r_issued_cnt + 16'd1;
            if (w_reject) r_stall_cnt  <= r_stall_cnt + 16'd1;
        end
    end

    assign instr_ready = !w_full;
    assign unit        = r_unit;
    assign reg1        = r_reg1;
    assign reg2        = r_reg2;
    assign reg3        = r_reg3;
    assign hasimm      = r_hasimm;
    assign imm         = r_imm;
    assign enable      = r_enable;
    assign issued_cnt  = r_issued_cnt;
    assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_issue_unit.sv
// ============================================================================
// Module : tb_issue_unit
// Brief  : Directed scoreboard bench for issue_unit acting as fetch and RS.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_issue_unit;
    import issue_unit_pkg::*;

    typedef struct packed {
        logic [1:0]  unit;
        logic        hasimm;
        logic [5:0]  r1;
        logic [5:0]  r2;
        logic [5:0]  r3;
        logic [31:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  unit;
    logic [5:0]  reg1;
    logic [5:0]  reg2;
    logic [5:0]  reg3;
    logic        hasimm;
    logic [31:0] imm;
    logic        enable;
    logic        rs_out;
    logic [15:0] issued_cnt;
    logic [15:0] stall_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   exp_issued = 0;
    int   exp_stall  = 0;
    int   en_count   = 0;
    bit   issue_prev = 0;
    bit   wait_now   = 0;

    issue_unit #(.DEPTH(8), .IMM_BITS(11)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .unit        (unit),
        .reg1        (reg1),
        .reg2        (reg2),
        .reg3        (reg3),
        .hasimm      (hasimm),
        .imm         (imm),
        .enable      (enable),
        .rs_out      (rs_out),
        .issued_cnt  (issued_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; acts as the RS: outcome of a WAIT cycle is scored at its closing edge
    task automatic step;
        if (wait_now && !flush && !rst) begin
            if (rs_out) begin
                exp_issued++;
                if (q.size() > 0) void'(q.pop_front());
            end else begin
                exp_stall++;
            end
        end
        wait_now = 0;
        @(posedge clk);
        #1;
        if (issue_prev) begin
            check("enable_width", {31'b0, enable}, 32'd0);
            issue_prev = 0;
            wait_now   = 1;
        end else if (enable === 1'b1) begin
            en_count++;
            issue_prev = 1;
            if (q.size() == 0) begin
                check("spurious_enable", {31'b0, enable}, 32'd0);
            end else begin
                check("unit",   {30'b0, unit},   {30'b0, q[0].unit});
                check("reg1",   {26'b0, reg1},   {26'b0, q[0].r1});
                check("reg2",   {26'b0, reg2},   {26'b0, q[0].r2});
                check("reg3",   {26'b0, reg3},   {26'b0, q[0].r3});
                check("hasimm", {31'b0, hasimm}, {31'b0, q[0].hasimm});
                check("imm",    imm,             q[0].imm);
            end
        end
    endtask

    task automatic push(input logic [1:0] u, input logic h, input logic [5:0] r1,
                        input logic [5:0] r2, input logic [5:0] r3, input logic [10:0] im);
        exp_t e;
        e.unit   = u;
        e.hasimm = h;
        e.r1     = r1;
        e.r2     = r2;
        e.r3     = h ? 6'd0 : r3;
        e.imm    = h ? {{21{im[10]}}, im} : 32'd0;
        check("instr_ready", {31'b0, instr_ready}, (q.size() < 8) ? 32'd1 : 32'd0);
        if (q.size() < 8) q.push_back(e);
        instr       = {u, h, r1, r2, r3, im};
        instr_valid = 1'b1;
        step;
        instr_valid = 1'b0;
    endtask

    task automatic wait_issued(input int n, input int budget);
        int t = 0;
        while (exp_issued < n && t < budget) begin
            step;
            t++;
        end
        if (exp_issued < n) check("timeout_issued", 32'(exp_issued), 32'(n));
    endtask

    task automatic wait_stall(input int n, input int budget);
        int t = 0;
        while (exp_stall < n && t < budget) begin
            step;
            t++;
        end
        if (exp_stall < n) check("timeout_stall", 32'(exp_stall), 32'(n));
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_issued"}, {16'b0, issued_cnt}, 32'(exp_issued));
        check({tag, "_stall"},  {16'b0, stall_cnt},  32'(exp_stall));
    endtask

    initial begin
        int en0;
        int t;
        rst         = 1'b1;
        flush       = 1'b0;
        instr       = 32'd0;
        instr_valid = 1'b0;
        rs_out      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enable", {31'b0, enable},      32'd0);
        check("rst_unit",   {30'b0, unit},        32'd0);
        check("rst_reg1",   {26'b0, reg1},        32'd0);
        check("rst_imm",    imm,                  32'd0);
        check("rst_ready",  {31'b0, instr_ready}, 32'd1);
        check_counters("rst");
        rst = 1'b0;
        step;

        // add r5,r1,r2 accepted first time; enable two cycles after push
        rs_out = 1'b1;
        push(UNIT_ADD, 1'b0, 6'd5, 6'd1, 6'd2, 11'd0);
        check("lat_idle", {31'b0, enable}, 32'd0);
        step;
        check("lat_issue", {31'b0, enable}, 32'd1);
        wait_issued(1, 20);
        check_counters("t1");

        // lw with negative-edge and positive immediates
        push(UNIT_LW, 1'b1, 6'd7, 6'd3, 6'h2A, 11'h7FF);
        push(UNIT_LW, 1'b1, 6'd8, 6'd4, 6'h15, 11'h3FF);
        wait_issued(3, 40);
        check("imm_pos_hold", imm, 32'h0000_03FF);
        check("reg3_imm",     {26'b0, reg3}, 32'd0);

        // three rejections then accept, same fields each attempt
        rs_out = 1'b0;
        en0 = en_count;
        push(UNIT_MUL, 1'b0, 6'd9, 6'd10, 6'd11, 11'd0);
        wait_stall(3, 40);
        rs_out = 1'b1;
        wait_issued(4, 20);
        check("retry_pulses", 32'(en_count - en0), 32'd4);
        check_counters("t3");

        // fill to full while RS refuses; ninth word dropped
        rs_out = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(UNIT_SW, 1'b0, 6'(i), 6'(i + 10), 6'(i + 20), 11'd0);
        end
        check("full_ready", {31'b0, instr_ready}, 32'd0);
        push(UNIT_ADD, 1'b0, 6'd63, 6'd63, 6'd63, 11'd0);
        rs_out = 1'b1;
        wait_issued(12, 200);
        check("drain_empty", 32'(q.size()), 32'd0);
        repeat (4) step;
        check_counters("t4");

        // flush while waiting on the RS with entries buffered
        rs_out = 1'b0;
        push(UNIT_ADD, 1'b0, 6'd1, 6'd2, 6'd3, 11'd0);
        push(UNIT_MUL, 1'b0, 6'd4, 6'd5, 6'd6, 11'd0);
        push(UNIT_SW,  1'b0, 6'd7, 6'd8, 6'd9, 11'd0);
        t = 0;
        while (!wait_now && t < 20) begin
            step;
            t++;
        end
        if (!wait_now) check("timeout_wait", {31'b0, wait_now}, 32'd1);
        flush = 1'b1;
        step;
        flush = 1'b0;
        q.delete();
        issue_prev = 0;
        wait_now   = 0;
        check("flush_enable", {31'b0, enable},      32'd0);
        check("flush_ready",  {31'b0, instr_ready}, 32'd1);
        repeat (4) step;
        check_counters("t5");

        // async reset during an ISSUE cycle
        rs_out = 1'b1;
        push(UNIT_MUL, 1'b1, 6'd33, 6'd34, 6'd35, 11'h155);
        t = 0;
        while (!issue_prev && t < 20) begin
            step;
            t++;
        end
        if (!issue_prev) check("timeout_issue", {31'b0, issue_prev}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_enable", {31'b0, enable}, 32'd0);
        check("arst_unit",   {30'b0, unit},   32'd0);
        check("arst_reg1",   {26'b0, reg1},   32'd0);
        check("arst_hasimm", {31'b0, hasimm}, 32'd0);
        check("arst_imm",    imm,             32'd0);
        q.delete();
        issue_prev = 0;
        wait_now   = 0;
        exp_issued = 0;
        exp_stall  = 0;
        check_counters("arst");
        #1 rst = 1'b0;
        repeat (4) step;
        push(UNIT_ADD, 1'b0, 6'd12, 6'd13, 6'd14, 11'd0);
        wait_issued(1, 20);
        check_counters("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
